// File: rtl/axi_cmd_pkg.sv
// Shared types and AXI encodings for the command arbiter.
package axi_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Burst attributes captured on accept; the address is kept separately since its width is a parameter.
    typedef struct packed {
        logic       write;
        logic [7:0] len;
        logic [2:0] size;
    } cmd_attr_t;

    // Higher encoding is the worse response.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 address and response channels used by the command arbiter.
interface axi4_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    logic                  rvalid;
    logic                  rready;
    logic                  rlast;
    logic [1:0]            rresp;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output bready,
        input  awready, arready, bvalid, bresp, rvalid, rready, rlast, rresp
    );

endinterface

// File: rtl/axi_rr_select.sv
// Round-robin pick: first asserted request after last_grant, wrapping.
module axi_rr_select #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       found
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned cand;

    // Walk from the farthest offset down so the nearest hit is the one left standing.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            cand = (32'(last_grant) + i) % NUM_REQ;
            if (req[IDX_W'(cand)]) begin
                grant = IDX_W'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Arbitrates per-requester burst commands onto one AXI master, one burst in flight.
module axi_cmd_arbiter
    import axi_cmd_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    input  logic [NUM_REQ*3-1:0]          req_size,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          grant_active,
    output logic [NUM_REQ-1:0]            done,
    output logic [1:0]                    done_resp,
    axi4_if.master                        master
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t            state;
    logic [IDX_W-1:0]      last_grant;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_found;
    logic                  accept_c;
    logic [ADDR_WIDTH-1:0] sel_addr;
    cmd_attr_t             sel_attr;
    logic [ADDR_WIDTH-1:0] addr_q;
    cmd_attr_t             attr_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  bready_q;
    logic [1:0]            rresp_acc;

    axi_rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (sel_idx),
        .found      (sel_found)
    );

    // Mux the winner's command fields out of the packed request buses.
    always_comb begin
        sel_addr = '0;
        sel_attr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_addr       = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_attr.write = req_write[i];
                sel_attr.len   = req_len[i*8 +: 8];
                sel_attr.size  = req_size[i*3 +: 3];
            end
        end
    end

    // Accept is combinational so the requester sees ready in the cycle it is chosen.
    always_comb begin
        req_ready = '0;
        accept_c  = resetn && (state == ST_IDLE) && sel_found;
        if (accept_c) begin
            req_ready = NUM_REQ'(1) << sel_idx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            grant_idx    <= '0;
            grant_active <= 1'b0;
            done         <= '0;
            done_resp    <= AXI_RESP_OKAY;
            addr_q       <= '0;
            attr_q       <= '0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            rresp_acc    <= AXI_RESP_OKAY;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        grant_idx    <= sel_idx;
                        last_grant   <= sel_idx;
                        grant_active <= 1'b1;
                        addr_q       <= sel_addr;
                        attr_q       <= sel_attr;
                        awvalid_q    <= sel_attr.write;
                        arvalid_q    <= !sel_attr.write;
                        rresp_acc    <= AXI_RESP_OKAY;
                        state        <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if ((awvalid_q && master.awready) || (arvalid_q && master.arready)) begin
                        awvalid_q <= 1'b0;
                        arvalid_q <= 1'b0;
                        bready_q  <= attr_q.write;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (attr_q.write) begin
                        if (master.bvalid) begin
                            bready_q         <= 1'b0;
                            done[grant_idx]  <= 1'b1;
                            done_resp        <= master.bresp;
                            grant_active     <= 1'b0;
                            state            <= ST_IDLE;
                        end
                    end else if (master.rvalid && master.rready) begin
                        rresp_acc <= resp_max(rresp_acc, master.rresp);
                        if (master.rlast) begin
                            done[grant_idx] <= 1'b1;
                            done_resp       <= resp_max(rresp_acc, master.rresp);
                            grant_active    <= 1'b0;
                            state           <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign master.awid    = ID_WIDTH'(grant_idx);
    assign master.awaddr  = addr_q;
    assign master.awlen   = attr_q.len;
    assign master.awsize  = attr_q.size;
    assign master.awburst = AXI_BURST_INCR;
    assign master.awvalid = awvalid_q;
    assign master.arid    = ID_WIDTH'(grant_idx);
    assign master.araddr  = addr_q;
    assign master.arlen   = attr_q.len;
    assign master.arsize  = attr_q.size;
    assign master.arburst = AXI_BURST_INCR;
    assign master.arvalid = arvalid_q;
    assign master.bready  = bready_q;

endmodule
